key_conditioner: RTL
====================

Name: key_conditioner

Overview:
- Conditions raw push-button inputs, active-low on the board, before they reach the experiment input adapter and the RAM write/clock path.
- Per key: 2-flop synchronisation into clk_100M, counter-based debounce, single-cycle press/release strobes, optional auto-repeat while held.
- Replaces direct use of bouncing buttons as clocks. Downstream logic uses key_press/key_pulse as clock enables in the clk_100M domain.

Parameters:
- NUM_KEYS, 4, number of independent button channels.
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles needed to accept a level change (10 ms at 100 MHz); must be >= 2.
- REPEAT_EN, 1, 1 enables auto-repeat, 0 means key_repeat is never asserted.
- REPEAT_DELAY, 50_000_000, cycles from accepted press to first repeat strobe.
- REPEAT_PERIOD, 10_000_000, cycles between subsequent repeat strobes.
- ACTIVE_LOW, 1, 1 means raw input 0 = pressed; 0 means raw input 1 = pressed.

Ports:
- clk_100M  input  1  system clock, 100 MHz.
- rst_n  input  1  asynchronous active-low reset.
- btn_raw  input  NUM_KEYS  raw asynchronous button pins.
- key_level  output  NUM_KEYS  debounced level, 1 = pressed.
- key_press  output  NUM_KEYS  1-cycle strobe on accepted press.
- key_release  output  NUM_KEYS  1-cycle strobe on accepted release.
- key_repeat  output  NUM_KEYS  1-cycle auto-repeat strobe while held.
- key_pulse  output  NUM_KEYS  key_press OR key_repeat, registered.

Behaviour:
- Reset (rst_n=0, async assert):
  - Sync flops load the released level.
  - Counters go to 0 and the FSM goes to IDLE.
  - All outputs are 0.
- Synchroniser: two flops per key. Polarity normalised after the second flop: s = btn_sync XOR ACTIVE_LOW, so 1 = pressed.
- Debounce, per key:
  - cnt clears whenever s == key_level.
  - Otherwise cnt increments.
  - When cnt == DEBOUNCE_CYCLES-1 and s != key_level, key_level toggles on that edge and cnt clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes key_level.
- Latency: raw edge to key_level change is 2 + DEBOUNCE_CYCLES clocks.
- Strobes:
  - key_press/key_release are registered.
  - They assert in the same cycle key_level changes, for exactly one cycle.
- Repeat FSM, per key: IDLE, DELAY, REPEAT.
  - IDLE -> DELAY on accepted press; rcnt=0.
  - DELAY: rcnt increments. At rcnt == REPEAT_DELAY-1: assert key_repeat, rcnt=0, go to REPEAT.
  - REPEAT: at rcnt == REPEAT_PERIOD-1: assert key_repeat, rcnt=0.
  - Accepted release in any state -> IDLE with no repeat strobe that cycle. Release wins over a coincident repeat terminal count.
  - REPEAT_EN=0: FSM stays in IDLE.
- key_pulse = key_press | key_repeat, same cycle. Press and repeat are never both 1.
- Counter widths: $clog2 of the largest count + 1. No wrap; counters saturate-free because they clear at terminal.
- Channels are fully independent. Simultaneous events on different keys are all reported in the same cycle.
- Reset mid-operation: all state is abandoned immediately. After release, a still-held key is re-accepted after 2 + DEBOUNCE_CYCLES clocks, which produces a fresh key_press.

Decomposition:
- Shared constants in key_pkg (a localparam include for Verilog builds): FSM state encodings KEY_IDLE=2'd0, KEY_DELAY=2'd1, KEY_REPEAT=2'd2, and a width helper.
- One sub-module, key_debounce_ch: a single channel holding the synchroniser, debounce counter, strobes and repeat FSM.
- The top instantiates NUM_KEYS copies in a generate loop and ORs nothing across channels.

Test Plan (sim params DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5, ACTIVE_LOW=1, NUM_KEYS=4):
- Reset: hold rst_n=0, btn_raw=4'hF -> all outputs 0. Release reset with buttons idle for 50 cycles -> no strobes.
- Clean press: btn_raw[0] 1->0 and held -> key_level[0] and key_press[0]=1 exactly 10 clocks after the edge; key_press[0] stays high 1 cycle.
- Bounce: btn_raw[1] toggles every 3 cycles for 30 cycles, then stays 0 -> no key_press during toggling; key_press[1] occurs 10 clocks after the last edge.
- Auto-repeat: hold key 2 for 60 cycles after acceptance -> key_repeat[2] at +20, +25, +30, ... cycles after key_press; key_pulse[2] is high on every one of those cycles.
- Release race: release key 2 so key_level drops on the same cycle as a repeat terminal count -> key_release[2]=1, key_repeat[2]=0, FSM in IDLE.
- Reset mid-hold: assert rst_n=0 for 3 cycles while key 3 is held and repeating -> outputs 0 immediately (async). After deassert, key_press[3] occurs again after 10 clocks.

Source files
------------

// File: rtl/key_pkg.sv
// key_pkg: shared repeat-FSM encodings and counter-width helper for key_conditioner
package key_pkg;
  typedef enum logic [1:0] {
    KEY_IDLE   = 2'd0,
    KEY_DELAY  = 2'd1,
    KEY_REPEAT = 2'd2
  } key_state_t;
  // bits needed to hold values 0..n
  function automatic int cnt_w(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one button channel - sync, debounce, press/release strobes, auto-repeat
//   clk   : system clock
//   rst_n : async active-low reset
//   raw   : raw button pin
//   level : debounced level, 1 = pressed
//   press, rel, rpt, pulse : registered single-cycle strobes
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD   = 10_000_000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel,
  output logic rpt,
  output logic pulse
);
  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  localparam int RW = cnt_w(REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD);
  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic [RW-1:0] rcnt;
  key_state_t    state;
  logic s, diff, hit, up, dn, r_term, r_hit;
  assign s      = sync[1] ^ ACTIVE_LOW;
  assign diff   = s != level;
  assign hit    = diff && cnt == CW'(DEBOUNCE_CYCLES - 1);
  assign up     = hit && !level;
  assign dn     = hit && level;
  assign r_term = (state == KEY_DELAY && rcnt == RW'(REPEAT_DELAY - 1)) ||
                  (state == KEY_REPEAT && rcnt == RW'(REPEAT_PERIOD - 1));
  // a coincident release suppresses the repeat strobe
  assign r_hit  = r_term && !dn;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= {2{ACTIVE_LOW}};
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
      rpt   <= 1'b0;
      pulse <= 1'b0;
      state <= KEY_IDLE;
      rcnt  <= '0;
    end else begin
      sync  <= {sync[0], raw};
      cnt   <= (diff && !hit) ? cnt + 1'b1 : '0;
      level <= level ^ hit;
      press <= up;
      rel   <= dn;
      rpt   <= r_hit;
      pulse <= up || r_hit;
      if (dn) begin
        state <= KEY_IDLE;
        rcnt  <= '0;
      end else if (up) begin
        state <= REPEAT_EN ? KEY_DELAY : KEY_IDLE;
        rcnt  <= '0;
      end else if (state != KEY_IDLE) begin
        state <= r_term ? KEY_REPEAT : state;
        rcnt  <= r_term ? '0 : rcnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: NUM_KEYS independent button conditioning channels
//   clk_100M : system clock
//   rst_n    : async active-low reset
//   btn_raw  : raw button pins
//   key_level/key_press/key_release/key_repeat/key_pulse : per-key outputs
module key_conditioner
  import key_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD   = 10_000_000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic                clk_100M,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] btn_raw,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_repeat,
  output logic [NUM_KEYS-1:0] key_pulse
);
  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_EN      (REPEAT_EN),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_ch (
      .clk  (clk_100M),
      .rst_n(rst_n),
      .raw  (btn_raw[g]),
      .level(key_level[g]),
      .press(key_press[g]),
      .rel  (key_release[g]),
      .rpt  (key_repeat[g]),
      .pulse(key_pulse[g])
    );
  end
endmodule
